// File: rtl/fft_r22sdf_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : fft_r22sdf_ctrl
// Purpose  : Sequencer for a radix-2^2 SDF FFT pipeline. It drives the
//            butterfly selects, the twiddle addresses, input zeroing and the
//            output frame flags.
// Revision : 1.0  initial release
// ============================================================================
module fft_r22sdf_ctrl #(
   parameter int N      = 64,
   parameter int TW_LAT = 1,
   localparam int LOGN  = $clog2(N),
   localparam int NST   = LOGN / 2
) (
   input  logic                       clk_i,
   input  logic                       rst_n,
   input  logic                       valid_i,
   output logic                       zero_in_o,
   output logic [NST-1:0]             bfi_sel_o,
   output logic [NST-1:0]             bfii_sel_o,
   output logic [NST-1:0]             bfii_tsel_o,
   output logic [(NST-1)*LOGN-1:0]    tw_addr_o,
   output logic                       valid_o,
   output logic                       sof_o,
   output logic                       err_o,
   output logic                       busy_o
);

   localparam int              PIPE_LAT = N - 1 + TW_LAT * (NST - 1);
   localparam int              LW       = $clog2(PIPE_LAT + 1);
   localparam logic [LW-1:0]   LAT_FULL = LW'(PIPE_LAT);
   localparam logic [LW-1:0]   LAT_LAST = LW'(PIPE_LAT - 1);
   localparam logic [LOGN-1:0] SOF_CNT  = LOGN'(PIPE_LAT % N);

   // Cumulative delay of stage s relative to the master count.
   function automatic int stage_off(input int s);
      int acc;
      acc = 0;
      for (int j = 0; j < s; j++) begin
         acc = acc + (3 * (N >> (2 * j))) / 4 + TW_LAT;
      end
      return acc;
   endfunction

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FILL  = 2'd1,
      RUN   = 2'd2,
      FLUSH = 2'd3
   } state_t;

   state_t                    r_state;
   state_t                    w_state_n;
   logic [LOGN-1:0]           r_cnt;
   logic [LOGN-1:0]           w_cnt_n;
   logic [LW-1:0]             r_age;
   logic [LW-1:0]             w_age_inc;
   logic [LW-1:0]             r_fl;
   logic [LW-1:0]             w_fl_n;
   logic                      r_hold;
   logic                      w_hold_n;
   logic                      r_err;
   logic                      w_err_n;
   logic                      w_frame_edge;
   logic                      w_ctl_en;
   logic                      w_valid_n;
   logic                      w_sof_n;
   logic [NST-1:0]            w_bfi_n;
   logic [NST-1:0]            w_bfii_n;
   logic [NST-1:0]            w_tsel_n;
   logic [(NST-1)*LOGN-1:0]   w_tw_n;
   logic                      r_valid;
   logic                      r_sof;
   logic [NST-1:0]            r_bfi;
   logic [NST-1:0]            r_bfii;
   logic [NST-1:0]            r_tsel;
   logic [(NST-1)*LOGN-1:0]   r_tw;

   assign w_frame_edge = (r_cnt == '0);

   // r_age counts cycles since sample 0 and saturates once the pipe is full.
   always_comb begin
      w_age_inc = r_age;
      if (r_state == IDLE) begin
         w_age_inc = LW'(1);
      end else if (r_age != LAT_FULL) begin
         w_age_inc = r_age + LW'(1);
      end
   end

   always_comb begin
      w_state_n = r_state;
      w_hold_n  = r_hold;
      w_err_n   = r_err;
      w_fl_n    = r_fl;
      case (r_state)
         IDLE: begin
            if (valid_i) begin
               w_state_n = FILL;
            end
         end
         FILL, RUN: begin
            if (w_frame_edge) begin
               w_hold_n = 1'b0;
               if (!valid_i) begin
                  w_state_n = FLUSH;
                  w_fl_n    = LW'(1);
               end else if (r_state == FILL && w_age_inc == LAT_FULL) begin
                  w_state_n = RUN;
               end
            end else begin
               if (!valid_i) begin
                  w_hold_n = 1'b1;
                  w_err_n  = 1'b1;
               end
               if (r_state == FILL && w_age_inc == LAT_FULL) begin
                  w_state_n = RUN;
               end
            end
         end
         FLUSH: begin
            if (w_frame_edge && valid_i) begin
               w_state_n = (w_age_inc == LAT_FULL) ? RUN : FILL;
            end else begin
               if (!w_frame_edge && valid_i) begin
                  w_err_n = 1'b1;
               end
               if (r_fl == LAT_LAST) begin
                  w_state_n = IDLE;
               end else begin
                  w_fl_n = r_fl + LW'(1);
               end
            end
         end
         default: w_state_n = IDLE;
      endcase
   end

   assign w_cnt_n   = (w_state_n == IDLE) ? '0 : r_cnt + LOGN'(1);
   assign w_ctl_en  = (w_state_n != IDLE);
   assign w_valid_n = (w_state_n == RUN) ||
                      ((w_state_n == FLUSH) && (w_age_inc == LAT_FULL));
   assign w_sof_n   = w_valid_n && (w_cnt_n == SOF_CNT);

   // Zeroing follows valid_i in the same cycle so a missing sample never
   // reaches the first butterfly.
   always_comb begin
      zero_in_o = 1'b0;
      case (r_state)
         FILL, RUN: zero_in_o = !valid_i || (r_hold && !w_frame_edge);
         FLUSH:     zero_in_o = !(valid_i && w_frame_edge);
         default:   zero_in_o = 1'b0;
      endcase
   end

   genvar s;
   generate
      for (s = 0; s < NST; s++) begin : g_stage
         localparam int            MB    = LOGN - 2 * s;
         localparam logic [MB-1:0] OFF_S = MB'(stage_off(s) % N);
         logic [MB-1:0]            w_c;

         // Only the low log2(M_s) bits of the local count matter here.
         assign w_c         = w_cnt_n[MB-1:0] - OFF_S;
         assign w_bfi_n[s]  = w_c[MB-1];
         assign w_bfii_n[s] = w_c[MB-2];
         assign w_tsel_n[s] = ~w_c[MB-1];

         if (s < NST - 1) begin : g_tw
            localparam logic [MB-1:0] N_MASK = MB'((1 << (MB - 2)) - 1);
            logic [LOGN-1:0]          w_k;
            logic [LOGN-1:0]          w_n;
            logic [LOGN-1:0]          w_prod;

            assign w_k    = LOGN'({w_c[MB-2], w_c[MB-1]});
            assign w_n    = LOGN'(w_c & N_MASK);
            assign w_prod = w_k * w_n;
            assign w_tw_n[s*LOGN +: LOGN] = w_prod << (2 * s);
         end
      end
   endgenerate

   always_ff @(posedge clk_i) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_n;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_n) begin
         r_cnt   <= '0;
         r_age   <= '0;
         r_fl    <= '0;
         r_hold  <= 1'b0;
         r_err   <= 1'b0;
         r_valid <= 1'b0;
         r_sof   <= 1'b0;
         r_bfi   <= '0;
         r_bfii  <= '0;
         r_tsel  <= '0;
         r_tw    <= '0;
      end else begin
         r_cnt   <= w_cnt_n;
         r_age   <= (w_state_n == IDLE) ? '0 : w_age_inc;
         r_fl    <= w_fl_n;
         r_hold  <= w_hold_n;
         r_err   <= w_err_n;
         r_valid <= w_valid_n;
         r_sof   <= w_sof_n;
         r_bfi   <= w_ctl_en ? w_bfi_n  : '0;
         r_bfii  <= w_ctl_en ? w_bfii_n : '0;
         r_tsel  <= w_ctl_en ? w_tsel_n : '0;
         r_tw    <= w_ctl_en ? w_tw_n   : '0;
      end
   end

   assign bfi_sel_o   = r_bfi;
   assign bfii_sel_o  = r_bfii;
   assign bfii_tsel_o = r_tsel;
   assign tw_addr_o   = r_tw;
   assign valid_o     = r_valid;
   assign sof_o       = r_sof;
   assign err_o       = r_err;
   assign busy_o      = (r_state != IDLE);

endmodule
`default_nettype wire
